// File: rtl/lrpt_pkg.sv
// Shared types for the LRPT Viterbi front-end.
// Soft symbol type, scheduler states and frame constants.
package lrpt_pkg;

    typedef logic signed [7:0] soft_t;

    localparam soft_t SOFT_ZERO = 8'sh00;

    localparam int CADU_BITS = 8192;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SLIP,
        FLUSH
    } vit_sched_state_t;

endpackage

// File: rtl/vit_sched_ctrl_if.sv
// Signal bundle between demod, scheduler and Viterbi decoder.
// slave = scheduler side, master = surrounding system.
interface vit_sched_ctrl_if;
    import lrpt_pkg::*;

    soft_t sym_in;
    logic  sym_valid_in;
    logic  sym_ready_out;
    logic  slip_req;
    logic  flush_req;
    soft_t vit_soft_out;
    logic  vit_valid_out;
    logic  vit_ready_in;
    logic  vit_bit_in;
    logic  vit_bit_valid_in;
    logic  bit_out;
    logic  bit_valid_out;
    logic  frame_start_out;
    logic  pair_phase;
    logic  busy;
    logic  flushing;

    modport slave (
        input  sym_in, sym_valid_in, slip_req, flush_req,
        input  vit_ready_in, vit_bit_in, vit_bit_valid_in,
        output sym_ready_out, vit_soft_out, vit_valid_out,
        output bit_out, bit_valid_out, frame_start_out,
        output pair_phase, busy, flushing
    );

    modport master (
        output sym_in, sym_valid_in, slip_req, flush_req,
        output vit_ready_in, vit_bit_in, vit_bit_valid_in,
        input  sym_ready_out, vit_soft_out, vit_valid_out,
        input  bit_out, bit_valid_out, frame_start_out,
        input  pair_phase, busy, flushing
    );

endinterface

// File: rtl/soft_fifo.sv
// Small synchronous skid FIFO of soft symbols.
// Head is read combinationally; pushes when full are dropped.
module soft_fifo
    import lrpt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    input  logic                   push,
    input  soft_t                  din,
    input  logic                   pop,
    output soft_t                  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    soft_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vit_sched_ctrl.sv
// Feeds I/Q soft symbols into the Viterbi decoder, handles
// pair slips and trellis flush, and frames the decoded bits.
module vit_sched_ctrl
    import lrpt_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FLUSH_PAIRS = 64,
    parameter int FRAME_BITS  = CADU_BITS
) (
    input  logic            clk,
    input  logic            sys_rst,
    vit_sched_ctrl_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int ZW = $clog2(2 * FLUSH_PAIRS + 1);
    localparam int BW = $clog2(FRAME_BITS);

    localparam logic [ZW-1:0] Z_EVEN = ZW'(2 * FLUSH_PAIRS - 1);
    localparam logic [ZW-1:0] Z_ODD  = ZW'(2 * FLUSH_PAIRS);
    localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);

    vit_sched_state_t state, state_nx;

    soft_t          fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_cnt;
    logic           push;
    logic           pop;
    logic           load;
    logic           load_zero;
    logic           z_start;
    logic           z_dec;
    logic           done;
    logic           can_load;
    logic           xfer;

    soft_t          soft_q;
    logic           valid_q;
    logic           phase_q;
    logic [ZW-1:0]  z_left;
    logic           z_init;

    logic [BW-1:0]  bit_cnt;
    logic [BW-1:0]  bit_idx;
    logic           bit_q;
    logic           bit_vld_q;
    logic           fs_q;

    assign bus.sym_ready_out = !sys_rst && !fifo_full
                               && state != FLUSH;
    assign push     = bus.sym_valid_in && bus.sym_ready_out;
    assign can_load = !valid_q || bus.vit_ready_in;
    assign xfer     = valid_q && bus.vit_ready_in;

    soft_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .sys_rst (sys_rst),
        .push    (push),
        .din     (bus.sym_in),
        .pop     (pop),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        load      = 1'b0;
        load_zero = 1'b0;
        z_start   = 1'b0;
        z_dec     = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_cnt != '0) state_nx = RUN;
            end
            RUN: begin
                if (bus.flush_req) begin
                    state_nx = FLUSH;
                end else if (bus.slip_req) begin
                    state_nx = SLIP;
                end else if (!fifo_empty && can_load) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end
            end
            SLIP: begin
                if (bus.flush_req) begin
                    state_nx = FLUSH;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = RUN;
                end
            end
            FLUSH: begin
                // queued data first, then the zero tail
                if (!fifo_empty) begin
                    pop  = can_load;
                    load = can_load;
                end else if (!z_init) begin
                    load      = can_load;
                    load_zero = can_load;
                    z_start   = can_load;
                end else if (z_left != '0) begin
                    load      = can_load;
                    load_zero = can_load;
                    z_dec     = can_load;
                end else if (xfer) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            soft_q  <= SOFT_ZERO;
            valid_q <= 1'b0;
            phase_q <= 1'b0;
            z_left  <= '0;
            z_init  <= 1'b0;
        end else begin
            if (load) begin
                soft_q  <= load_zero ? SOFT_ZERO : fifo_head;
                valid_q <= 1'b1;
            end else if (can_load) begin
                valid_q <= 1'b0;
            end
            if (done)      phase_q <= 1'b0;
            else if (xfer) phase_q <= ~phase_q;
            // phase of the first zero decides the extra pad
            if (z_start) begin
                z_left <= (phase_q ^ valid_q) ? Z_ODD : Z_EVEN;
                z_init <= 1'b1;
            end else if (z_dec) begin
                z_left <= z_left - 1'b1;
            end
            if (done) z_init <= 1'b0;
        end
    end

    assign bit_idx = done ? '0 : bit_cnt;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            bit_cnt   <= '0;
            bit_q     <= 1'b0;
            bit_vld_q <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            bit_q     <= bus.vit_bit_in;
            bit_vld_q <= bus.vit_bit_valid_in;
            fs_q      <= bus.vit_bit_valid_in
                         && bit_idx == '0;
            if (bus.vit_bit_valid_in)
                bit_cnt <= (bit_idx == B_LAST) ? '0
                           : bit_idx + 1'b1;
            else
                bit_cnt <= bit_idx;
        end
    end

    assign bus.vit_soft_out    = soft_q;
    assign bus.vit_valid_out   = valid_q;
    assign bus.pair_phase      = phase_q;
    assign bus.bit_out         = bit_q;
    assign bus.bit_valid_out   = bit_vld_q;
    assign bus.frame_start_out = fs_q;
    assign bus.busy            = state != IDLE;
    assign bus.flushing        = state == FLUSH;

endmodule
